// File: rtl/increment_sequencer.sv
// increment_sequencer: loads a start value and a target, then counts up by one
// on each step while running until the count reaches the target.
// Outputs are all registered; carry/overflow/sat are sticky until the next start.
// Optional build macro: SATURATE_EN -- when defined, a step at all-ones holds the
// count, raises sat and finishes the sequence instead of wrapping to zero.
module increment_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] target,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             overflow,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned maximum (wrap point) and signed maximum (signed overflow point).
    localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] count_inc;

`ifdef SATURATE_EN
    logic             sat_r;
    assign sat = sat_r;
`else
    assign sat = 1'b0;
`endif

    assign count_inc = count + WIDTH'(1);

    // Sequencer FSM: state, count, captured target and all registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            tgt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
`ifdef SATURATE_EN
            sat_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= load_val;
                        tgt      <= target;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
`ifdef SATURATE_EN
                        sat_r    <= 1'b0;
`endif
                        // A zero-length sequence skips RUN entirely.
                        if (load_val == target) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (step) begin
                        if (count == SMAX) begin
                            overflow <= 1'b1;
                        end
`ifdef SATURATE_EN
                        // At all-ones the count pins and the sequence ends early.
                        if (count == UMAX) begin
                            sat_r <= 1'b1;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else
`endif
                        begin
                            count <= count_inc;
                            if (count == UMAX) begin
                                carry <= 1'b1;
                            end
                            if (count_inc == tgt) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/increment_sequencer.md
INCREMENT_SEQUENCER -- requirements
Module: increment_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, count/operand width in bits; all values below assume WIDTH=4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to load and begin a sequence; sampled only in IDLE.
REQ-005 SHALL have port: load_val  input  WIDTH  start value, captured on accepted start.
REQ-006 SHALL have port: target  input  WIDTH  end value, captured on accepted start.
REQ-007 SHALL have port: step  input  1  increment-by-1 enable while RUN.
REQ-008 SHALL have port: count  output  WIDTH  registered current value.
REQ-009 SHALL have port: busy  output  1  high in RUN.
REQ-010 SHALL have port: done  output  1  one-cycle pulse in DONE.
REQ-011 SHALL have port: carry  output  1  sticky; set on unsigned wrap 1111->0000.
REQ-012 SHALL have port: overflow  output  1  sticky; set on signed overflow 0111->1000.
REQ-013 SHALL have port: sat  output  1  sticky saturation flag; constant 0 when SATURATE_EN undefined.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-015 In IDLE, start=1 SHALL capture load_val into count and target into an internal register, clear carry/overflow/sat, and go to RUN next cycle.
REQ-016 If load_val==target at accepted start, FSM SHALL go to DONE instead of RUN (count=load_val, no increments).
REQ-017 In RUN with step=1, count SHALL become count+1 modulo 2^WIDTH on the next edge (latency 1 cycle); step=0 holds count.
REQ-018 In RUN, when the incremented value equals the captured target, FSM SHALL go to DONE on that same edge.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE; count and sticky flags hold their values in IDLE until the next accepted start.
REQ-020 start SHALL be ignored in RUN and DONE; step SHALL be ignored in IDLE and DONE.
REQ-021 Increment from 0111 SHALL set overflow; increment from 1111 SHALL set carry (wrap mode); flags never clear except on start or reset.
REQ-022 Input changes to target/load_val after start SHALL not affect the running sequence.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state IDLE, count=0000, busy=0, done=0, carry=0, overflow=0, sat=0, internal target=0000.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abandon the sequence with no done pulse; reset SHALL have priority over start and step.

Configuration
REQ-025 Macro SATURATE_EN SHALL select saturation behaviour at compile time.
REQ-026 With SATURATE_EN defined, step at count=1111 in RUN (target!=1111) SHALL hold count at 1111, set sat, not set carry, and go to DONE.
REQ-027 Without SATURATE_EN, count SHALL wrap 1111->0000, set carry, and remain in RUN until target is reached; sat SHALL be tied to 0.

Verification
REQ-028 Reset then start, load_val=0010, target=0101, step held 1 -> busy 3 cycles, count 0011,0100,0101, done pulse one cycle, carry=0, overflow=0.
REQ-029 start, load_val=0110, target=1001, step=1 -> overflow=1 after 0111->1000, done when count=1001, overflow still 1 in IDLE.
REQ-030 Wrap mode: load_val=1110, target=0001, step=1 -> count 1111,0000,0001, carry=1 at 0000, done after 3 steps; SATURATE_EN: count 1111, 1111, sat=1, done, carry=0.
REQ-031 start with load_val=target=1010 -> no busy cycle, done pulse next cycle, count=1010.
REQ-032 Step toggled 1,0,0,1 mid-RUN and start pulsed during RUN -> count advances only on step=1 cycles, start ignored, captured target unchanged.
REQ-033 rst_n=0 for one cycle while RUN with count=0100 -> next cycle IDLE, count=0000, all flags 0, no done pulse.
